i2c_master_sequencer: RTL and testbench
=======================================

Name: i2c_master_sequencer

Overview:
- Command-level I2C master controller. Sequences the bus-phase state machine (START, repeated START, byte write, byte read, STOP) using one phase counter against `dbl_clock_divisor`.
- Drives open-drain SCL/SDA enables.
- Sits between the host command interface and the pads.
- Phase state codes and timing rule are shared with the existing phase helpers: `k_start1`, `k_start2`, etc. in `include/i2c.vh`.

Parameters:
- CTR_W, 16, width of phase counter and `dbl_clock_divisor`.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dbl_clock_divisor  in  CTR_W  phase length minus one, in clk cycles (half SCL period)
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd  in  2  0=START, 1=WRITE, 2=READ, 3=STOP
- cmd_data  in  8  byte for WRITE
- cmd_ack  in  1  ack bit sent after READ (0=ACK, 1=NACK)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  8  byte received by READ (holds until next READ completes)
- rsp_nack  out  1  sampled ACK bit after WRITE (1=NACK)
- rsp_err  out  1  command illegal in current bus state
- busy  out  1  high while not in k_idle or k_hold
- scl_oe  out  1  1 = pull SCL low
- sda_oe  out  1  1 = pull SDA low
- sda_i  in  1  SDA pad input (pre-synchronised)

Behaviour:
- Reset (synchronous, active-high):
  - state=k_idle, ctr_reg=0.
  - scl_oe=0, sda_oe=0.
  - cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_nack=0, rsp_err=0, bit index=7.
  - Reset mid-phase abandons the transfer immediately; no STOP is generated.
- Phase timing:
  - ctr_reg increments each cycle.
  - When ctr_reg >= dbl_clock_divisor, the state advances and ctr_reg<=0.
  - Each phase therefore lasts divisor+1 cycles; divisor=0 gives 1-cycle phases.
  - Divisor is compared live. Lowering it below ctr_reg ends the phase next cycle.
- Bus states:
  - k_idle (bus free, both released).
  - k_hold (we own the bus, scl_oe=1, SDA unchanged from last phase).
  - cmd_ready=1 only in these two states.
- Phase sequences, listed as (scl_oe, sda_oe) per phase:
  - START from idle: k_start1(0,0) -> k_start2(0,1) -> k_hold.
  - START from hold (repeated start): k_rstart(1,0) -> k_start1 -> k_start2 -> k_hold.
  - WRITE: 8x [k_bit_low(1,~b) -> k_bit_high(0,~b)], MSB first. Then k_ack_low(1,0) -> k_ack_high(0,0).
    - sda_i is sampled on the last cycle of k_ack_high into rsp_nack.
    - Then k_hold.
  - READ: 8x [k_bit_low(1,0) -> k_bit_high(0,0)], shifting in sda_i on the last cycle of each k_bit_high, MSB first.
    - Then k_ack_low(1,~cmd_ack) -> k_ack_high(0,~cmd_ack) -> k_hold.
  - STOP from hold: k_stop1(1,1) -> k_stop2(0,1) -> k_stop3(0,0) -> k_idle.
- Illegal commands:
  - In k_idle, WRITE/READ/STOP are accepted and discarded.
  - The next cycle gives rsp_valid=1, rsp_err=1, with no bus activity.
  - START is always legal.
- Completion:
  - rsp_valid pulses exactly one cycle, on the cycle after the final phase of the command ends.
  - No backpressure; rsp_err=0 for legal commands.
  - rsp_nack is updated only by WRITE; rsp_data only by READ.
- Capture: cmd, cmd_data and cmd_ack are captured at acceptance; later input changes are ignored.
- busy is 0 in k_idle and k_hold, 1 otherwise.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- With the macro defined:
  - Adds input scl_i.
  - In every phase where scl_oe=0, ctr_reg holds at 0 while scl_i=0 (slave stretching). Counting resumes once scl_i=1.
- Without the macro: no scl_i port; phases are purely counter-timed.

Decomposition:
- `include/i2c.vh` holds:
  - state localparams (k_idle, k_hold, k_rstart, k_start1, k_start2, k_bit_low, k_bit_high, k_ack_low, k_ack_high, k_stop1, k_stop2, k_stop3), 4-bit;
  - command encodings.
- Phase "next" logic lives in `hw/next_*.v` task includes, matching next_start1 (state_next/ctr_next from ctr_reg/dbl_clock_divisor_reg).
- One natural sub-module: i2c_phase_timer (counter, terminal-count compare, stretch hold).

Test Plan:
- divisor=3, START from idle -> k_start1 for 4 cycles (0,0), then k_start2 for 4 cycles (0,1), then rsp_valid pulse with rsp_err=0, then k_hold with scl_oe=1.
- After START, WRITE 0xA5 with sda_i=0 at ack -> sda_oe per bit =~{1,0,1,0,0,1,0,1}; rsp_nack=0. Repeat with sda_i=1 -> rsp_nack=1.
- READ with sda_i driving 0x3C, cmd_ack=1 -> rsp_data=0x3C, sda_oe=0 throughout the ack phases.
- WRITE in k_idle -> rsp_valid=1, rsp_err=1 next cycle; scl_oe/sda_oe stay 0; state stays k_idle.
- START from hold -> k_rstart(1,0) precedes k_start1. Then STOP -> k_stop3 ends with both released, busy=0, cmd_ready=1.
- reset asserted mid-WRITE bit 4 -> next cycle state=k_idle, scl_oe=0, sda_oe=0, ctr_reg=0, no rsp_valid.

Source files
------------

// File: rtl/i2c_master_sequencer_pkg.sv
// Shared definitions for the I2C master sequencer.
//   state_e   : bus-phase state codes (4-bit)
//   cmd_e     : host command encodings
//   cmd_req_t : command fields captured at acceptance
//   is_parked : true in the two states where a new command may be taken
package i2c_master_sequencer_pkg;

  typedef enum logic [3:0] {
    k_idle     = 4'd0,
    k_hold     = 4'd1,
    k_rstart   = 4'd2,
    k_start1   = 4'd3,
    k_start2   = 4'd4,
    k_bit_low  = 4'd5,
    k_bit_high = 4'd6,
    k_ack_low  = 4'd7,
    k_ack_high = 4'd8,
    k_stop1    = 4'd9,
    k_stop2    = 4'd10,
    k_stop3    = 4'd11
  } state_e;

  typedef enum logic [1:0] {
    k_cmd_start = 2'd0,
    k_cmd_write = 2'd1,
    k_cmd_read  = 2'd2,
    k_cmd_stop  = 2'd3
  } cmd_e;

  typedef struct packed {
    cmd_e op;
    logic ack;   // ack bit to send after a READ (1 = NACK)
  } cmd_req_t;

  function automatic logic is_parked(state_e s);
    return (s == k_idle) || (s == k_hold);
  endfunction

endpackage

// File: rtl/i2c_master_sequencer_phase_timer.sv
// Phase timer for the I2C master sequencer.
//   clk, reset        : system clock, synchronous active-high reset
//   run               : a timed bus phase is in progress
//   stretch           : slave is holding SCL low; freeze the count at zero
//   dbl_clock_divisor : phase length minus one (compared live)
//   tc                : last cycle of the current phase
module i2c_master_sequencer_phase_timer #(
  parameter int CTR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             stretch,
  input  logic [CTR_W-1:0] dbl_clock_divisor,
  output logic             tc
);

  logic [CTR_W-1:0] ctr_reg;

  // >= rather than == so a divisor lowered below the count ends the phase
  assign tc = run & ~stretch & (ctr_reg >= dbl_clock_divisor);

  always_ff @(posedge clk) begin
    if (reset || !run || stretch || tc) ctr_reg <= '0;
    else                                ctr_reg <= ctr_reg + 1'b1;
  end

endmodule

// File: rtl/i2c_master_sequencer.sv
// Command-level I2C master: sequences START / repeated START / byte WRITE /
// byte READ / STOP bus phases and drives open-drain SCL/SDA enables.
// Ports:
//   clk, reset            : system clock, synchronous active-high reset
//   dbl_clock_divisor     : phase length minus one (half SCL period)
//   cmd_valid/cmd_ready   : command handshake; cmd, cmd_data, cmd_ack captured
//   rsp_valid             : one-cycle completion pulse
//   rsp_data / rsp_nack   : READ byte / WRITE ack sample (held between updates)
//   rsp_err               : command was illegal in the current bus state
//   busy                  : a bus phase is in progress
//   scl_oe / sda_oe       : 1 pulls the line low
//   sda_i                 : SDA pad input (already synchronised)
//   scl_i                 : SCL pad input, only with I2C_CLOCK_STRETCH_EN
// Build option: define I2C_CLOCK_STRETCH_EN to honour slave clock stretching.
module i2c_master_sequencer
  import i2c_master_sequencer_pkg::*;
#(
  parameter int CTR_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CTR_W-1:0] dbl_clock_divisor,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd,
  input  logic [7:0]       cmd_data,
  input  logic             cmd_ack,
  output logic             rsp_valid,
  output logic [7:0]       rsp_data,
  output logic             rsp_nack,
  output logic             rsp_err,
  output logic             busy,
  output logic             scl_oe,
  output logic             sda_oe,
`ifdef I2C_CLOCK_STRETCH_EN
  input  logic             scl_i,
`endif
  input  logic             sda_i
);

  state_e   state, state_next;
  cmd_req_t req_q;
  logic [2:0] bit_idx;
  logic [7:0] shreg;     // WRITE: byte being sent; READ: byte being gathered
  logic       sda_last;  // SDA level of the previous cycle, held in k_hold
  logic       accept, tc, stretch;
  logic       done_evt, err_evt;
  logic       bit_sda, ack_sda;

  assign cmd_ready = is_parked(state);
  assign busy      = ~cmd_ready;
  assign accept    = cmd_valid & cmd_ready;

`ifdef I2C_CLOCK_STRETCH_EN
  // only meaningful while we have released SCL ourselves
  assign stretch = busy & ~scl_oe & ~scl_i;
`else
  assign stretch = 1'b0;
`endif

  i2c_master_sequencer_phase_timer #(.CTR_W(CTR_W)) u_timer (
    .clk               (clk),
    .reset             (reset),
    .run               (busy),
    .stretch           (stretch),
    .dbl_clock_divisor (dbl_clock_divisor),
    .tc                (tc)
  );

  assign bit_sda = (req_q.op == k_cmd_write) ? ~shreg[bit_idx] : 1'b0;
  assign ack_sda = (req_q.op == k_cmd_read)  ? ~req_q.ack      : 1'b0;

  always_ff @(posedge clk) begin
    if (reset) state <= k_idle;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    scl_oe     = 1'b0;
    sda_oe     = 1'b0;
    done_evt   = 1'b0;
    err_evt    = 1'b0;
    case (state)
      k_idle: begin
        if (accept) begin
          if (cmd_e'(cmd) == k_cmd_start) state_next = k_start1;
          else                            err_evt    = 1'b1;
        end
      end
      k_hold: begin
        scl_oe = 1'b1;
        sda_oe = sda_last;
        if (accept) begin
          case (cmd_e'(cmd))
            k_cmd_start: state_next = k_rstart;
            k_cmd_write,
            k_cmd_read:  state_next = k_bit_low;
            default:     state_next = k_stop1;
          endcase
        end
      end
      k_rstart: begin
        scl_oe = 1'b1;
        if (tc) state_next = k_start1;
      end
      k_start1: begin
        if (tc) state_next = k_start2;
      end
      k_start2: begin
        sda_oe = 1'b1;
        if (tc) begin
          state_next = k_hold;
          done_evt   = 1'b1;
        end
      end
      k_bit_low: begin
        scl_oe = 1'b1;
        sda_oe = bit_sda;
        if (tc) state_next = k_bit_high;
      end
      k_bit_high: begin
        sda_oe = bit_sda;
        if (tc) state_next = (bit_idx == 3'd0) ? k_ack_low : k_bit_low;
      end
      k_ack_low: begin
        scl_oe = 1'b1;
        sda_oe = ack_sda;
        if (tc) state_next = k_ack_high;
      end
      k_ack_high: begin
        sda_oe = ack_sda;
        if (tc) begin
          state_next = k_hold;
          done_evt   = 1'b1;
        end
      end
      k_stop1: begin
        scl_oe = 1'b1;
        sda_oe = 1'b1;
        if (tc) state_next = k_stop2;
      end
      k_stop2: begin
        sda_oe = 1'b1;
        if (tc) state_next = k_stop3;
      end
      k_stop3: begin
        if (tc) begin
          state_next = k_idle;
          done_evt   = 1'b1;
        end
      end
      default: state_next = k_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= '0;
      bit_idx   <= 3'd7;
      shreg     <= '0;
      sda_last  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
      rsp_nack  <= 1'b0;
    end else begin
      sda_last  <= sda_oe;
      rsp_valid <= done_evt | err_evt;
      rsp_err   <= err_evt;
      if (accept) begin
        req_q   <= '{op: cmd_e'(cmd), ack: cmd_ack};
        shreg   <= cmd_data;
        bit_idx <= 3'd7;
      end
      if (tc) begin
        case (state)
          k_bit_high: begin
            if (req_q.op == k_cmd_read) shreg <= {shreg[6:0], sda_i};
            bit_idx <= bit_idx - 3'd1;  // 0 wraps back to 7 for the next byte
          end
          k_ack_high: begin
            if (req_q.op == k_cmd_write) rsp_nack <= sda_i;
            if (req_q.op == k_cmd_read)  rsp_data <= shreg;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Self-checking bench for i2c_master_sequencer. The reference model expands
// each command into the expected per-cycle (scl_oe, sda_oe) list straight
// from the phase tables, and tracks bus ownership and response registers.
module tb_i2c_master_sequencer;
  localparam int CTR_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [CTR_W-1:0] div = 16'd3;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd = 2'd0;
  logic [7:0]       cmd_data = 8'd0;
  logic             cmd_ack = 1'b0;
  logic             sda_i = 1'b1;
  logic             cmd_ready, rsp_valid, rsp_nack, rsp_err, busy, scl_oe, sda_oe;
  logic [7:0]       rsp_data;

  i2c_master_sequencer #(.CTR_W(CTR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .dbl_clock_divisor (div),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd               (cmd),
    .cmd_data          (cmd_data),
    .cmd_ack           (cmd_ack),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_nack          (rsp_nack),
    .rsp_err           (rsp_err),
    .busy              (busy),
    .scl_oe            (scl_oe),
    .sda_oe            (sda_oe),
`ifdef I2C_CLOCK_STRETCH_EN
    .scl_i             (1'b1),
`endif
    .sda_i             (sda_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model state
  bit         owned  = 1'b0;
  bit         held   = 1'b0;
  logic [7:0] m_data = 8'd0;
  logic       m_nack = 1'b0;
  logic [2:0] exp_q[$];   // {scl_oe, sda_oe, sda_i to drive}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic push_phase(input bit scl, input bit sda, input bit sin);
    for (int k = 0; k <= int'(div); k++) exp_q.push_back({scl, sda, sin});
  endtask

  task automatic check_reset(input string tag);
    chk(tag, 32'({scl_oe, sda_oe, busy, cmd_ready, rsp_valid, rsp_err, rsp_nack}), 32'h08);
    chk({tag, "_data"}, 32'(rsp_data), 32'h0);
    chk({tag, "_ctr"}, 32'(dut.u_timer.ctr_reg), 32'h0);
  endtask

  // c: command, d: write byte, a: ack to send after read, rd: byte the
  // slave returns, nk: slave ack bit after write, abort_at: cycle index
  // at which reset is asserted (-1 = never)
  task automatic run_cmd(input logic [1:0] c, input logic [7:0] d, input logic a,
                         input logic [7:0] rd, input logic nk, input int abort_at);
    bit legal;
    logic [2:0] e;
    @(negedge clk);
    chk("parked", 32'({rsp_valid, cmd_ready, busy}), 32'h2);
    cmd_valid = 1'b1; cmd = c; cmd_data = d; cmd_ack = a;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd = 2'($urandom); cmd_data = 8'($urandom); cmd_ack = 1'($urandom);
    legal = (c == 2'd0) || owned;
    if (!legal) begin
      @(negedge clk);
      chk("err_rsp", 32'({rsp_valid, rsp_err, scl_oe, sda_oe, busy}), 32'h18);
      chk("err_keep", 32'({rsp_data, rsp_nack}), 32'({m_data, m_nack}));
      return;
    end
    exp_q.delete();
    case (c)
      2'd0: begin
        if (owned) push_phase(1'b1, 1'b0, 1'($urandom));
        push_phase(1'b0, 1'b0, 1'($urandom));
        push_phase(1'b0, 1'b1, 1'($urandom));
      end
      2'd1: begin
        for (int i = 7; i >= 0; i--) begin
          push_phase(1'b1, !d[i], 1'($urandom));
          push_phase(1'b0, !d[i], 1'($urandom));
        end
        push_phase(1'b1, 1'b0, 1'($urandom));
        push_phase(1'b0, 1'b0, nk);
      end
      2'd2: begin
        for (int i = 7; i >= 0; i--) begin
          push_phase(1'b1, 1'b0, rd[i]);
          push_phase(1'b0, 1'b0, rd[i]);
        end
        push_phase(1'b1, !a, 1'($urandom));
        push_phase(1'b0, !a, 1'($urandom));
      end
      default: begin
        push_phase(1'b1, 1'b1, 1'($urandom));
        push_phase(1'b0, 1'b1, 1'($urandom));
        push_phase(1'b0, 1'b0, 1'($urandom));
      end
    endcase
    for (int k = 0; k < exp_q.size(); k++) begin
      e = exp_q[k];
      @(negedge clk);
      sda_i = e[0];
      chk("bus", 32'({scl_oe, sda_oe, rsp_valid, busy}), 32'({e[2], e[1], 2'b01}));
      if (k == abort_at) begin
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset("abort");
        reset = 1'b0; sda_i = 1'b1;
        owned = 1'b0; held = 1'b0; m_data = 8'd0; m_nack = 1'b0;
        return;
      end
    end
    @(negedge clk);
    sda_i = 1'b1;
    case (c)
      2'd0: begin owned = 1'b1; held = 1'b1; end
      2'd1: begin held = 1'b0; m_nack = nk; end
      2'd2: begin held = !a; m_data = rd; end
      default: begin owned = 1'b0; held = 1'b0; end
    endcase
    chk("rsp", 32'({rsp_valid, rsp_err}), 32'h2);
    chk("rsp_data", 32'(rsp_data), 32'(m_data));
    chk("rsp_nack", 32'(rsp_nack), 32'(m_nack));
    chk("park_bus", 32'({scl_oe, sda_oe, busy, cmd_ready}), 32'({owned, owned & held, 2'b01}));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    reset = 1'b0;

    div = 16'd3;
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1);  // START from idle
    run_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b0, -1);  // WRITE, ACK
    run_cmd(2'd1, 8'hA5, 1'b0, 8'h00, 1'b1, -1);  // WRITE, NACK
    run_cmd(2'd2, 8'h00, 1'b1, 8'h3C, 1'b0, -1);  // READ, send NACK
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1);  // repeated START
    run_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1);  // STOP
    run_cmd(2'd1, 8'h55, 1'b0, 8'h00, 1'b0, -1);  // illegal in idle
    run_cmd(2'd2, 8'h00, 1'b0, 8'h99, 1'b0, -1);  // illegal in idle
    run_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1);  // illegal in idle

    div = 16'd0;                                   // one-cycle phases
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    run_cmd(2'd1, 8'h81, 1'b0, 8'h00, 1'b1, -1);
    run_cmd(2'd2, 8'h00, 1'b0, 8'hC3, 1'b0, -1);
    run_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      div = 16'($urandom_range(0, 3));
      run_cmd(2'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), -1);
    end

    // reset while the fourth-from-top data bit (bit 4) is on the bus
    div = 16'd3;
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    run_cmd(2'd1, 8'hF0, 1'b0, 8'h00, 1'b0, 6 * 4 + 1);
    repeat (3) begin
      @(negedge clk);
      chk("post_abort", 32'({rsp_valid, scl_oe, sda_oe, busy}), 32'h0);
    end
    run_cmd(2'd1, 8'h12, 1'b0, 8'h00, 1'b0, -1);  // bus released -> illegal
    run_cmd(2'd0, 8'h00, 1'b0, 8'h00, 1'b0, -1);
    run_cmd(2'd3, 8'h00, 1'b0, 8'h00, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
